// File: rtl/spi_slave_word.sv
// ============================================================================
// Module   : spi_slave_word
// Purpose  : Oversampled SPI slave moving DATA_W-bit words in any SPI mode.
//            sclk, cs_n and mosi are synchronised into clk. The fabric gets
//            an rx strobe and a ready/valid transmit holding register.
//            Back-to-back words are supported, and an aborted frame is flagged.
// Options  : define SPI_SLAVE_ECHO_EN so that an empty word load returns the
//            last received word instead of zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_word #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int                CNT_W       = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  c_last_bit  = CNT_W'(DATA_W - 1);
  localparam logic              c_sclk_idle = (CPOL != 0);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_sclk_sync;
  logic [SYNC_STAGES-1:0]  r_cs_sync;
  logic [SYNC_STAGES-1:0]  r_mosi_sync;
  logic                    r_sclk_prev;
  logic                    r_cs_prev;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_W-1:0]       r_rx_shift;
  logic [DATA_W-1:0]       r_rx_data;
  logic                    r_rx_valid;
  logic                    r_word_done;
  logic                    r_frame_err;
  logic [DATA_W-1:0]       r_tx_shift;
  logic [DATA_W-1:0]       r_hold;
  logic                    r_hold_full;
  logic                    r_miso;

  logic w_sclk_s, w_cs_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic w_sample, w_shift, w_cs_fall, w_cs_rise;
  logic w_load, w_abort;
  logic [DATA_W-1:0] w_empty_word;
  logic [DATA_W-1:0] w_load_word;
  logic              w_shift_out;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_lead      = (CPOL == 0) ? w_sclk_rise : w_sclk_fall;
  assign w_trail     = (CPOL == 0) ? w_sclk_fall : w_sclk_rise;
  assign w_sample    = (CPHA == 0) ? w_lead : w_trail;
  assign w_shift     = (CPHA == 0) ? w_trail : w_lead;
  assign w_cs_fall   = ~w_cs_s & r_cs_prev;
  assign w_cs_rise   = w_cs_s & ~r_cs_prev;

  // Value loaded when the holding register is empty and nothing bypasses;
  // at a word boundary the just-completed word is what rx_data is taking.
`ifdef SPI_SLAVE_ECHO_EN
  assign w_empty_word = r_word_done ? r_rx_shift : r_rx_data;
`else
  assign w_empty_word = '0;
`endif

  assign w_load_word = r_hold_full ? r_hold : (i_tx_valid ? i_tx_data : w_empty_word);
  // CPHA=0 already shows the MSB, so a shift edge exposes the next bit down.
  assign w_shift_out = (CPHA == 0) ? r_tx_shift[DATA_W-2] : r_tx_shift[DATA_W-1];

  // Synchronisers plus one delay stage for edge detection. cs_n resets to
  // "low" so a cs_n held low across reset can never look like a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= {SYNC_STAGES{c_sclk_idle}};
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= c_sclk_idle;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, word-load request and frame-abort detection.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ACTIVE;
          w_load      = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_abort     = (r_cnt != '0);
        end else if (r_word_done) begin
          w_load = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Receive path: sample mosi, count bits, commit completed words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_word_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_word_done <= 1'b0;
      r_frame_err <= w_abort;
      if (r_word_done) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end
      if (r_state == IDLE || w_cs_rise) begin
        r_cnt <= '0;
        if (w_abort) r_rx_shift <= '0;
      end else if (w_sample) begin
        r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi_s};
        if (r_cnt == c_last_bit) begin
          r_cnt       <= '0;
          r_word_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Transmit holding register and its ready/valid handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_load && r_hold_full) begin
      r_hold_full <= 1'b0;
    end else if (i_tx_valid && !r_hold_full && !w_load) begin
      r_hold      <= i_tx_data;
      r_hold_full <= 1'b1;
    end
  end

  // Transmit shifter and miso. With CPHA=0 the trailing edge right after a
  // word's last sample is skipped so the freshly loaded MSB stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= '0;
      r_miso     <= 1'b0;
    end else if (w_load) begin
      r_tx_shift <= w_load_word;
      if (CPHA == 0) r_miso <= w_load_word[DATA_W-1];
    end else if (w_state_nxt == IDLE) begin
      r_miso <= 1'b0;
    end else if (w_shift && (CPHA != 0 || r_cnt != '0)) begin
      r_miso     <= w_shift_out;
      r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
    end
  end

  assign o_miso      = r_miso;
  assign o_tx_ready  = ~r_hold_full;
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state == ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_word.sv
// ============================================================================
// Module   : tb_spi_slave_word
// Purpose  : Directed bench for spi_slave_word: 8-bit mode 0, 8-bit mode 3
//            and 16-bit mode 0 instances share sclk/mosi with separate cs_n.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_word;

  localparam int H = 8;  // sclk half period in clk cycles

  logic        clk;
  logic        rst_n;
  logic        sclk;
  logic        mosi;
  logic [2:0]  cs_n;
  logic [2:0]  tx_valid;
  logic [31:0] tx_data [3];

  logic [2:0]  miso, tx_ready, rx_valid, ferr, busy;
  logic [7:0]  rxd0, rxd1;
  logic [15:0] rxd2;
  logic [31:0] w_rxd [3];

  assign w_rxd[0] = {24'h0, rxd0};
  assign w_rxd[1] = {24'h0, rxd1};
  assign w_rxd[2] = {16'h0, rxd2};

  spi_slave_word #(.DATA_W(8), .CPOL(0), .CPHA(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n[0]), .i_mosi(mosi),
    .o_miso(miso[0]), .i_tx_data(tx_data[0][7:0]), .i_tx_valid(tx_valid[0]),
    .o_tx_ready(tx_ready[0]), .o_rx_data(rxd0), .o_rx_valid(rx_valid[0]),
    .o_frame_err(ferr[0]), .o_busy(busy[0]));

  spi_slave_word #(.DATA_W(8), .CPOL(1), .CPHA(1)) u_m3 (
    .clk(clk), .rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n[1]), .i_mosi(mosi),
    .o_miso(miso[1]), .i_tx_data(tx_data[1][7:0]), .i_tx_valid(tx_valid[1]),
    .o_tx_ready(tx_ready[1]), .o_rx_data(rxd1), .o_rx_valid(rx_valid[1]),
    .o_frame_err(ferr[1]), .o_busy(busy[1]));

  spi_slave_word #(.DATA_W(16), .CPOL(0), .CPHA(0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n[2]), .i_mosi(mosi),
    .o_miso(miso[2]), .i_tx_data(tx_data[2][15:0]), .i_tx_valid(tx_valid[2]),
    .o_tx_ready(tx_ready[2]), .o_rx_data(rxd2), .o_rx_valid(rx_valid[2]),
    .o_frame_err(ferr[2]), .o_busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters per instance; tests work on deltas across a frame.
  int          rxv_cnt [3];
  int          ferr_cnt [3];
  int          rdy_low_cnt [3];
  logic [31:0] cap [3][64];

  initial begin
    for (int d = 0; d < 3; d++) begin
      rxv_cnt[d] = 0; ferr_cnt[d] = 0; rdy_low_cnt[d] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rx_valid[d]) begin
        cap[d][rxv_cnt[d] % 64] = w_rxd[d];
        rxv_cnt[d] = rxv_cnt[d] + 1;
      end
      if (ferr[d])      ferr_cnt[d]    = ferr_cnt[d] + 1;
      if (!tx_ready[d]) rdy_low_cnt[d] = rdy_low_cnt[d] + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_push(input int d, input logic [31:0] data);
    tx_data[d]  = data;
    tx_valid[d] = 1'b1;
    cyc(1);
    tx_valid[d] = 1'b0;
    cyc(2);
  endtask

  // Master model for modes 0 and 3; returns the bits it sampled on miso.
  task automatic frame(input int d, input int mode, input logic [31:0] word,
                       input int nbits, input bit byp, input logic [31:0] byp_data,
                       input int inj_bit, input logic [31:0] inj_data,
                       input bit keep_cs, output logic [31:0] mw);
    mw   = '0;
    sclk = (mode == 3);
    cyc(4);
    cs_n[d] = 1'b0;
    if (byp) begin
      // Land tx_valid exactly on the internal cs_n-fall load cycle.
      cyc(2);
      tx_data[d]  = byp_data;
      tx_valid[d] = 1'b1;
      cyc(1);
      tx_valid[d] = 1'b0;
      cyc(5);
    end else begin
      cyc(8);
    end
    for (int i = 0; i < nbits; i++) begin
      if (mode == 0) begin
        mosi = word[nbits-1-i];
        cyc(H);
        mw   = {mw[30:0], miso[d]};
        sclk = 1'b1;
        cyc(H);
        sclk = 1'b0;
      end else begin
        sclk = 1'b0;
        mosi = word[nbits-1-i];
        cyc(H);
        mw   = {mw[30:0], miso[d]};
        sclk = 1'b1;
        cyc(H);
      end
      if (i == inj_bit) begin
        tx_data[d]  = inj_data;
        tx_valid[d] = 1'b1;
        cyc(1);
        tx_valid[d] = 1'b0;
      end
    end
    cyc(H);
    if (!keep_cs) begin
      cs_n[d] = 1'b1;
      cyc(10);
    end
  endtask

  typedef struct {
    bit          pre_en;
    logic [31:0] pre_data;
    bit          byp_en;
    logic [31:0] byp_data;
    logic [31:0] mosi_word;
    int          nbits;
    int          exp_rxv;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [31:0] exp_miso;
    int          exp_ferr;
    bit          exp_rdy_low;
  } vec_t;

  vec_t        vt [5];
  bit          echo;
  logic [31:0] mw;
  int          b_rxv, b_ferr, b_rdy;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef SPI_SLAVE_ECHO_EN
    echo = 1'b1;
`else
    echo = 1'b0;
`endif
    // Sequence on the mode-0 instance; state carries from one row to the next.
    vt[0] = '{1, 32'h3C, 0, 32'h0, 32'hA5,   8,  1, 32'hA5, 32'hA5, 32'h3C, 0, 1};
    vt[1] = '{0, 32'h0,  0, 32'h0, 32'h1F,   5,  0, 32'h0,  32'hA5,
              echo ? 32'h14 : 32'h0, 1, 0};
    vt[2] = '{0, 32'h0,  0, 32'h0, 32'h0F,   8,  1, 32'h0F, 32'h0F,
              echo ? 32'hA5 : 32'h0, 0, 0};
    vt[3] = '{0, 32'h0,  1, 32'hE7, 32'h3A,  8,  1, 32'h3A, 32'h3A, 32'hE7, 0, 0};
    vt[4] = '{0, 32'h0,  0, 32'h0, 32'h7712, 16, 2, 32'h77, 32'h12,
              echo ? 32'h3A77 : 32'h0, 0, 0};

    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 3'b111; tx_valid = 3'b000;
    for (int d = 0; d < 3; d++) tx_data[d] = '0;
    cyc(4);
    check("reset_miso",      {31'h0, miso[0]},     32'h0);
    check("reset_tx_ready",  {29'h0, tx_ready},    32'h7);
    check("reset_rx_data",   w_rxd[0],             32'h0);
    check("reset_rx_valid",  {29'h0, rx_valid},    32'h0);
    check("reset_frame_err", {29'h0, ferr},        32'h0);
    check("reset_busy",      {29'h0, busy},        32'h0);
    rst_n = 1'b1;
    cyc(6);

    for (int v = 0; v < 5; v++) begin
      if (vt[v].pre_en) tx_push(0, vt[v].pre_data);
      b_rxv = rxv_cnt[0]; b_ferr = ferr_cnt[0]; b_rdy = rdy_low_cnt[0];
      frame(0, 0, vt[v].mosi_word, vt[v].nbits, vt[v].byp_en, vt[v].byp_data,
            -1, 32'h0, 0, mw);
      check($sformatf("v%0d_rx_valid_count", v), rxv_cnt[0] - b_rxv, vt[v].exp_rxv);
      if (vt[v].exp_rxv > 0)
        check($sformatf("v%0d_rx_first", v), cap[0][b_rxv % 64], vt[v].exp_first);
      check($sformatf("v%0d_rx_data", v), w_rxd[0], vt[v].exp_last);
      check($sformatf("v%0d_miso", v), mw, vt[v].exp_miso);
      check($sformatf("v%0d_frame_err", v), ferr_cnt[0] - b_ferr, vt[v].exp_ferr);
      check($sformatf("v%0d_rdy_low", v), {31'h0, (rdy_low_cnt[0] - b_rdy) > 0},
            {31'h0, vt[v].exp_rdy_low});
      check($sformatf("v%0d_tx_ready_end", v), {31'h0, tx_ready[0]}, 32'h1);
      check($sformatf("v%0d_busy_end", v), {31'h0, busy[0]}, 32'h0);
    end

    // Reset mid-frame with a word pending in the holding register.
    frame(0, 0, 32'h5, 3, 0, 32'h0, 0, 32'hFF, 1, mw);
    check("rst_pending_ready", {31'h0, tx_ready[0]}, 32'h0);
    check("rst_busy_before",   {31'h0, busy[0]},     32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_tx_ready",  {31'h0, tx_ready[0]}, 32'h1);
    check("rst_busy",      {31'h0, busy[0]},     32'h0);
    check("rst_rx_data",   w_rxd[0],             32'h0);
    check("rst_miso",      {31'h0, miso[0]},     32'h0);
    cyc(2);
    cs_n[0] = 1'b1;
    sclk    = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    b_rxv = rxv_cnt[0]; b_ferr = ferr_cnt[0];
    frame(0, 0, 32'h99, 8, 0, 32'h0, -1, 32'h0, 0, mw);
    check("post_rst_rx_valid_count", rxv_cnt[0] - b_rxv, 32'd1);
    check("post_rst_rx_data",  w_rxd[0], 32'h99);
    check("post_rst_miso",     mw,       32'h0);
    check("post_rst_frame_err", ferr_cnt[0] - b_ferr, 32'd0);

    // Mode 3, two words under one cs_n, 0x81 queued during the first word.
    b_rxv = rxv_cnt[1]; b_ferr = ferr_cnt[1];
    frame(1, 3, 32'h5AC3, 16, 0, 32'h0, 2, 32'h81, 0, mw);
    check("m3_rx_valid_count", rxv_cnt[1] - b_rxv, 32'd2);
    check("m3_rx_first",       cap[1][b_rxv % 64],       32'h5A);
    check("m3_rx_second",      cap[1][(b_rxv + 1) % 64], 32'hC3);
    check("m3_miso",           mw,       32'h0081);
    check("m3_frame_err",      ferr_cnt[1] - b_ferr, 32'd0);
    check("m3_tx_ready_end",   {31'h0, tx_ready[1]}, 32'h1);

    // 16-bit word; a second tx_valid while the register is full is dropped.
    tx_push(2, 32'h1234);
    check("w16_ready_after_push", {31'h0, tx_ready[2]}, 32'h0);
    tx_data[2]  = 32'hFFFF;
    tx_valid[2] = 1'b1;
    cyc(3);
    tx_valid[2] = 1'b0;
    check("w16_ready_still_low", {31'h0, tx_ready[2]}, 32'h0);
    b_rxv = rxv_cnt[2];
    frame(2, 0, 32'hBEEF, 16, 0, 32'h0, -1, 32'h0, 0, mw);
    check("w16_rx_valid_count", rxv_cnt[2] - b_rxv, 32'd1);
    check("w16_rx_data",  w_rxd[2], 32'hBEEF);
    check("w16_miso",     mw,       32'h1234);
    check("w16_tx_ready_end", {31'h0, tx_ready[2]}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_slave_word.md
Name: spi_slave_word

Overview:
- Parametrised SPI slave with an oversampled front end. Runs entirely on the system clock.
- Receives DATA_W-bit words on mosi and transmits DATA_W-bit words on miso in any of the four SPI modes.
- Exposes a one-cycle rx strobe and a ready/valid transmit holding register to the fabric (PWM, BCD display, LED logic).
- Successor to the fixed 8-bit, mode-0, sclk-clocked shifter. Adds a fabric-side transmit handshake, frame-abort detection and back-to-back words.

Parameters:
- DATA_W, 8: word width in bits; legal range 2..32.
- CPOL, 0: sclk idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- SYNC_STAGES, 2: synchroniser depth for sclk, cs_n and mosi; legal range 2..3.

Ports:
- clk  in  1  system clock, rising edge. Reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from master, asynchronous to clk.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmit holding register is empty.
- rx_data  out  DATA_W  last complete received word.
- rx_valid  out  1  one-cycle strobe: rx_data updated.
- frame_err  out  1  one-cycle strobe: cs_n rose mid-word.
- busy  out  1  frame in progress (synchronised cs_n low).

Behaviour:
- Reset values: miso=0, rx_data=0, rx_valid=0, tx_ready=1, frame_err=0, busy=0. Holding register and shift registers are cleared, bit counter=0, state=IDLE.
- Synchronisers: sclk, cs_n and mosi each pass through SYNC_STAGES flops. All edges are detected on the synchronised signals.
  - Supported sclk rate is at most clk/8.
  - Latency from a pin edge to internal action is SYNC_STAGES+1 clk cycles.
- Leading edge is rising if CPOL=0, falling if CPOL=1. Sample edge is the leading edge if CPHA=0, the trailing edge if CPHA=1. The shift edge is the other edge.
- Words are MSB first.
- FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on synchronised cs_n falling.
  - ACTIVE -> IDLE on synchronised cs_n rising.
  - sclk edges are ignored in IDLE.
- Word load happens on cs_n falling and after every completed word:
  - If the holding register is full, the tx shift register takes its content and tx_ready returns to 1 next cycle.
  - If the holding register is empty, the tx shift register takes 0.
  - If the holding register is empty and tx_valid=1 in the load cycle, tx_data bypasses straight into the shift register and tx_ready stays 1.
- miso:
  - CPHA=0: drives the tx MSB from the cycle after load.
  - CPHA=1: MSB appears on the first leading edge.
  - Subsequent bits advance on each shift edge.
  - miso=0 in IDLE.
- Sample edge behaviour:
  - mosi is shifted into the rx register and the bit counter increments.
  - When the counter reaches DATA_W-1, it wraps to 0. The next cycle, rx_data takes the full word, rx_valid=1 for exactly one cycle, and a word load occurs, so back-to-back words need no cs_n toggle.
- Transmit handshake:
  - Accept when tx_valid && tx_ready; tx_ready falls the next cycle.
  - tx_valid while tx_ready=0 is ignored. tx_data is not sampled.
  - The holding register persists across frames until consumed.
- cs_n rising while the counter is non-zero:
  - frame_err=1 for one cycle.
  - The partial rx word is discarded, rx_data is unchanged and there is no rx_valid.
  - Counter cleared.
- cs_n rising with counter=0: no error, return to IDLE.
- There is no rx backpressure. The fabric must capture rx_data on rx_valid; rx_data holds until the next complete word.
- rst_n asserted mid-frame: everything returns to reset values immediately. After release, the block waits for the next cs_n falling edge. An in-progress frame is never resumed.

Optional Feature:
- Macro: SPI_SLAVE_ECHO_EN.
- Defined: when a word load finds the holding register empty and no bypass, the shift register takes the last received rx_data instead of 0, so the master reads back its previous word.
- Undefined: the empty-load value is 0.

Test Plan:
- DATA_W=8, CPOL=0, CPHA=0, tx 0x3C accepted before cs_n falls; master sends 0xA5 -> rx_data=0xA5 with one rx_valid pulse; miso bits 0,0,1,1,1,1,0,0; tx_ready back to 1 after load.
- CPOL=1, CPHA=1, master sends 0x5A, 0xC3 back-to-back under one cs_n low; tx 0x81 queued mid-first-word -> two rx_valid pulses with 0x5A then 0xC3; second word on miso = 0x81.
- Mode 0, cs_n raised after 5 sclk cycles -> frame_err pulse; no rx_valid; rx_data keeps previous value 0xA5; next full frame 0x0F received correctly.
- Empty holding register, master sends 0x77 then 0x12 -> miso returns 0x00 both words; with SPI_SLAVE_ECHO_EN, second word returns 0x77.
- rst_n pulsed low after 3 bits with tx 0xFF pending -> all outputs at reset values; tx_ready=1; next frame 0x99 received; miso returns 0x00.
- DATA_W=16, mode 0, master sends 0xBEEF -> single rx_valid; rx_data=0xBEEF; tx_valid asserted with tx_ready=0 is ignored.
